light_safety_monitor: RTL and testbench
=======================================

Name: light_safety_monitor

Overview:
Downstream stage of traffic_controller. It consumes the six NS/EW lamp signals, registers them and forwards them to the lamp drivers. It checks each cycle for illegal lamp patterns and timing. On any violation it overrides the lamps with a flashing all-red failsafe, latches a fault code and holds that state until an explicit recovery request arrives.

Parameters:
CLK_FREQ, 50_000_000, clk cycles per 1 s tick; 1 gives a tick every cycle (simulation).
MIN_YELLOW_S, 3, minimum yellow duration in ticks.
ALLRED_S, 2, solid all-red hold after recovery, in ticks.
FLASH_HALF_S, 1, ticks per flash half-period.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
ns_red_in, ns_yellow_in, ns_green_in  in  1 each  NS lamps from controller
ew_red_in, ew_yellow_in, ew_green_in  in  1 each  EW lamps from controller
clr_fault  in  1  recovery request, level-sensitive
ns_red, ns_yellow, ns_green  out  1 each  NS lamp drive
ew_red, ew_yellow, ew_green  out  1 each  EW lamp drive
fault  out  1  high while in FAULT_FLASH
fault_code  out  3  last detected fault, sticky

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-low.
- Reset values:
  - ns_red=ew_red=1, all other lamps 0.
  - fault=0, fault_code=0, state=PASS.
  - Previous-lamp registers = red/red, so a first green is legal.
  - Tick counter = 0, yellow counters = 0.
- Tick generation: counter runs 0..CLK_FREQ-1 and tick pulses when it reaches CLK_FREQ-1.
- Pipeline:
  - Inputs are registered into in_q at edge N.
  - Checks are combinational on in_q.
  - At edge N+1, lamps <= in_q (PASS) or the override value. Pass-through latency is 2 cycles.
  - A violating pattern never reaches the lamp outputs.
- Checks; if several fire together, the lowest code wins:
  - 1: NS not one-hot.
  - 2: EW not one-hot.
  - 3: NS non-red and EW non-red simultaneously (covers green/green and green/yellow).
  - 4: green -> red on either road without an intervening yellow.
  - 5: yellow -> non-yellow after fewer than MIN_YELLOW_S ticks of yellow.
- Yellow timing:
  - Per-road 8-bit counter, cleared when the road is not yellow.
  - Increments on tick while the road is yellow and saturates at 255.
- States:
  - PASS: lamps follow in_q. Any violation -> FAULT_FLASH, fault_code <= code, tick counter cleared.
  - FAULT_FLASH:
    - fault=1; yellow and green lamps are 0.
    - ns_red=ew_red=1 for FLASH_HALF_S ticks, then 0 for FLASH_HALF_S ticks, repeating. The first phase is on.
    - New violations are ignored and fault_code is not overwritten.
    - clr_fault=1 with no violation on in_q -> RECOVER_ALLRED, tick counter cleared.
    - clr_fault while in_q is violating is ignored.
  - RECOVER_ALLRED:
    - Solid red on both roads, fault=0, fault_code retained.
    - After ALLRED_S ticks -> PASS.
    - Any violation -> FAULT_FLASH with the new code.
- clr_fault is ignored in PASS and RECOVER_ALLRED.
- Reset asserted in any state forces reset values on the next edge, including mid-flash.

Decomposition:
- Shared package light_safety_pkg:
  - state enum {PASS, FAULT_FLASH, RECOVER_ALLRED}.
  - Fault code constants FC_NONE=0, FC_NS_ONEHOT=1, FC_EW_ONEHOT=2, FC_CONFLICT=3, FC_NO_YELLOW=4, FC_SHORT_YELLOW=5.
  - Packed lamp-bundle struct {red, yellow, green}.
- One sub-module: tick_gen (parameter CLK_FREQ; inputs clk, reset, clr; output tick), which can also be reused by traffic_controller.

Test Plan:
All scenarios use CLK_FREQ=1, MIN_YELLOW_S=3, ALLRED_S=2, FLASH_HALF_S=1.
1. Legal cycle NS G(5)/Y(3)/R with EW mirrored -> outputs equal inputs delayed 2 cycles; fault=0, fault_code=0 throughout.
2. Drive ns_green=ew_green=1 for 1 cycle -> lamps never show two greens; fault=1 and fault_code=3 two cycles after injection; ns_red/ew_red then toggle 1,0,1,0 each cycle.
3. Drive ns_red=ns_green=1 -> fault_code=1; drive NS green->red directly -> fault_code=4.
4. NS yellow held 2 cycles then red -> fault_code=5; yellow held exactly 3 cycles -> no fault.
5. In FAULT_FLASH, assert clr_fault while inputs still violate -> state remains; then clean inputs with clr_fault=1 -> 2 cycles solid red, fault=0, then pass-through resumes; fault_code remains at the prior value.
6. Assert reset (low) mid-FAULT_FLASH -> next edge ns_red=ew_red=1, fault=0, fault_code=0; release with legal inputs -> PASS.

Source files
------------

// File: rtl/light_safety_pkg.sv
// Shared types and fault codes for the lamp safety monitor and its tick generator.
package light_safety_pkg;

   typedef enum logic [1:0] {
      PASS           = 2'd0,
      FAULT_FLASH    = 2'd1,
      RECOVER_ALLRED = 2'd2
   } state_t;

   localparam logic [2:0] FC_NONE         = 3'd0;
   localparam logic [2:0] FC_NS_ONEHOT    = 3'd1;
   localparam logic [2:0] FC_EW_ONEHOT    = 3'd2;
   localparam logic [2:0] FC_CONFLICT     = 3'd3;
   localparam logic [2:0] FC_NO_YELLOW    = 3'd4;
   localparam logic [2:0] FC_SHORT_YELLOW = 3'd5;

   typedef struct packed {
      logic red;
      logic yellow;
      logic green;
   } lamp_t;

   localparam lamp_t LAMP_RED = 3'b100;
   localparam lamp_t LAMP_OFF = 3'b000;

   function automatic logic lamp_onehot(input lamp_t l);
      return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running tick divider: pulses once every CLK_FREQ clocks; clr restarts the period.
module tick_gen #(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/light_safety_monitor.sv
// Registers controller lamp requests, checks them for illegal patterns/timing and
// forwards them, or overrides with a flashing all-red failsafe until recovery.
//
// state          | meaning
// PASS           | lamps follow registered inputs
// FAULT_FLASH    | both reds flash, fault=1, waits for clr_fault on clean inputs
// RECOVER_ALLRED | solid red for ALLRED_S ticks, then back to PASS
module light_safety_monitor
   import light_safety_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int MIN_YELLOW_S = 3,
   parameter int ALLRED_S     = 2,
   parameter int FLASH_HALF_S = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ns_red_in,
   input  logic       ns_yellow_in,
   input  logic       ns_green_in,
   input  logic       ew_red_in,
   input  logic       ew_yellow_in,
   input  logic       ew_green_in,
   input  logic       clr_fault,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam logic [7:0]  YMIN        = 8'(MIN_YELLOW_S);
   localparam logic [15:0] HALF_LAST   = 16'(FLASH_HALF_S - 1);
   localparam logic [15:0] ALLRED_LAST = 16'(ALLRED_S - 1);

   lamp_t       ns_in, ew_in;
   lamp_t       ns_q, ew_q, ns_prev, ew_prev;
   lamp_t       ns_out, ew_out, ns_out_n, ew_out_n;
   logic [7:0]  ns_ycnt, ew_ycnt;
   state_t      state, state_n;
   logic [2:0]  code_q, code_n, viol_code;
   logic        violation;
   logic        flash_on, flash_on_n;
   logic [15:0] phase_cnt, phase_n;
   logic        tick, tick_clr;

   assign ns_in = lamp_t'({ns_red_in, ns_yellow_in, ns_green_in});
   assign ew_in = lamp_t'({ew_red_in, ew_yellow_in, ew_green_in});

   tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clr   (tick_clr),
      .tick  (tick)
   );

   // Lowest code wins when several checks fire in the same cycle.
   always_comb begin
      viol_code = FC_NONE;
      if (!lamp_onehot(ns_q)) begin
         viol_code = FC_NS_ONEHOT;
      end else if (!lamp_onehot(ew_q)) begin
         viol_code = FC_EW_ONEHOT;
      end else if (!ns_q.red && !ew_q.red) begin
         viol_code = FC_CONFLICT;
      end else if ((ns_prev.green && ns_q.red) || (ew_prev.green && ew_q.red)) begin
         viol_code = FC_NO_YELLOW;
      end else if ((ns_prev.yellow && !ns_q.yellow && (ns_ycnt < YMIN)) ||
                   (ew_prev.yellow && !ew_q.yellow && (ew_ycnt < YMIN))) begin
         viol_code = FC_SHORT_YELLOW;
      end
   end

   assign violation = (viol_code != FC_NONE);

   always_comb begin
      state_n    = state;
      code_n     = code_q;
      flash_on_n = flash_on;
      phase_n    = phase_cnt;
      tick_clr   = 1'b0;
      ns_out_n   = ns_q;
      ew_out_n   = ew_q;
      case (state)
         PASS: begin
            if (violation) begin
               state_n    = FAULT_FLASH;
               code_n     = viol_code;
               tick_clr   = 1'b1;
               flash_on_n = 1'b1;
               phase_n    = '0;
            end
         end
         FAULT_FLASH: begin
            if (clr_fault && !violation) begin
               state_n  = RECOVER_ALLRED;
               tick_clr = 1'b1;
               phase_n  = '0;
            end else if (tick) begin
               if (phase_cnt == HALF_LAST) begin
                  flash_on_n = ~flash_on;
                  phase_n    = '0;
               end else begin
                  phase_n = phase_cnt + 16'd1;
               end
            end
         end
         RECOVER_ALLRED: begin
            if (violation) begin
               state_n    = FAULT_FLASH;
               code_n     = viol_code;
               tick_clr   = 1'b1;
               flash_on_n = 1'b1;
               phase_n    = '0;
            end else if (tick) begin
               if (phase_cnt == ALLRED_LAST) begin
                  state_n = PASS;
                  phase_n = '0;
               end else begin
                  phase_n = phase_cnt + 16'd1;
               end
            end
         end
         default: begin
            state_n = PASS;
         end
      endcase
      // Lamps follow the state being entered so an override lands on the same edge.
      case (state_n)
         PASS: begin
            ns_out_n = ns_q;
            ew_out_n = ew_q;
         end
         FAULT_FLASH: begin
            ns_out_n = flash_on_n ? LAMP_RED : LAMP_OFF;
            ew_out_n = flash_on_n ? LAMP_RED : LAMP_OFF;
         end
         default: begin
            ns_out_n = LAMP_RED;
            ew_out_n = LAMP_RED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= PASS;
         code_q    <= FC_NONE;
         flash_on  <= 1'b0;
         phase_cnt <= '0;
         ns_q      <= LAMP_RED;
         ew_q      <= LAMP_RED;
         ns_prev   <= LAMP_RED;
         ew_prev   <= LAMP_RED;
         ns_out    <= LAMP_RED;
         ew_out    <= LAMP_RED;
         ns_ycnt   <= '0;
         ew_ycnt   <= '0;
      end else begin
         state     <= state_n;
         code_q    <= code_n;
         flash_on  <= flash_on_n;
         phase_cnt <= phase_n;
         ns_q      <= ns_in;
         ew_q      <= ew_in;
         ns_prev   <= ns_q;
         ew_prev   <= ew_q;
         ns_out    <= ns_out_n;
         ew_out    <= ew_out_n;
         if (!ns_q.yellow) begin
            ns_ycnt <= '0;
         end else if (tick && (ns_ycnt != 8'hFF)) begin
            ns_ycnt <= ns_ycnt + 8'd1;
         end
         if (!ew_q.yellow) begin
            ew_ycnt <= '0;
         end else if (tick && (ew_ycnt != 8'hFF)) begin
            ew_ycnt <= ew_ycnt + 8'd1;
         end
      end
   end

   assign ns_red     = ns_out.red;
   assign ns_yellow  = ns_out.yellow;
   assign ns_green   = ns_out.green;
   assign ew_red     = ew_out.red;
   assign ew_yellow  = ew_out.yellow;
   assign ew_green   = ew_out.green;
   assign fault      = (state == FAULT_FLASH);
   assign fault_code = code_q;

endmodule

// File: tb/tb_light_safety_monitor.sv
// Directed bench for light_safety_monitor with a one-tick-per-clock configuration.
module tb_light_safety_monitor;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic clk = 1'b0;
   logic reset;
   logic ns_red_in, ns_yellow_in, ns_green_in;
   logic ew_red_in, ew_yellow_in, ew_green_in;
   logic clr_fault;
   logic ns_red, ns_yellow, ns_green;
   logic ew_red, ew_yellow, ew_green;
   logic fault;
   logic [2:0] fault_code;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0] t1_ns [0:18];
   logic [2:0] t1_ew [0:18];
   logic [5:0] prev_in;
   logic       flash;

   light_safety_monitor #(
      .CLK_FREQ     (1),
      .MIN_YELLOW_S (3),
      .ALLRED_S     (2),
      .FLASH_HALF_S (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ns_red_in    (ns_red_in),
      .ns_yellow_in (ns_yellow_in),
      .ns_green_in  (ns_green_in),
      .ew_red_in    (ew_red_in),
      .ew_yellow_in (ew_yellow_in),
      .ew_green_in  (ew_green_in),
      .clr_fault    (clr_fault),
      .ns_red       (ns_red),
      .ns_yellow    (ns_yellow),
      .ns_green     (ns_green),
      .ew_red       (ew_red),
      .ew_yellow    (ew_yellow),
      .ew_green     (ew_green),
      .fault        (fault),
      .fault_code   (fault_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] lamps();
      return {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
   endfunction

   // Present inputs, let one rising edge pass, then settle before sampling.
   task automatic drive(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
      {ns_red_in, ns_yellow_in, ns_green_in} = ns;
      {ew_red_in, ew_yellow_in, ew_green_in} = ew;
      clr_fault = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive(R, R, 1'b0);
      drive(R, R, 1'b0);
      reset = 1'b1;
   endtask

   initial begin
      t1_ns = '{G, G, G, G, G, Y, Y, Y, R, R, R, R, R, R, R, R, R, R, R};
      t1_ew = '{R, R, R, R, R, R, R, R, G, G, G, G, G, Y, Y, Y, R, R, R};

      do_reset();
      check("rst_lamps", lamps(), 6'b100100);
      check("rst_fault", fault, 1'b0);
      check("rst_code", fault_code, 3'd0);

      // Legal cycle: lamps equal the inputs presented one step earlier.
      prev_in = {R, R};
      for (int i = 0; i < 19; i++) begin
         drive(t1_ns[i], t1_ew[i], 1'b0);
         check("t1_lamps", lamps(), prev_in);
         check("t1_fault", fault, 1'b0);
         check("t1_code", fault_code, 3'd0);
         prev_in = {t1_ns[i], t1_ew[i]};
      end

      // Green/green for one cycle.
      drive(G, G, 1'b0);
      check("t2_no_gg", lamps(), {R, R});
      drive(R, R, 1'b0);
      check("t2_fault", fault, 1'b1);
      check("t2_code", fault_code, 3'd3);
      check("t2_flash_on", lamps(), 6'b100100);
      flash = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(R, R, 1'b0);
         flash = ~flash;
         check("t2_flash", lamps(), flash ? 6'b100100 : 6'b000000);
         check("t2_fault_hold", fault, 1'b1);
      end

      // clr_fault while inputs violate is ignored; then clean inputs recover.
      drive(R, 3'b000, 1'b0);
      flash = ~flash;
      check("t5_flash_a", lamps(), flash ? 6'b100100 : 6'b000000);
      for (int i = 0; i < 2; i++) begin
         drive(R, 3'b000, 1'b1);
         flash = ~flash;
         check("t5_clr_ignored", fault, 1'b1);
         check("t5_code_kept", fault_code, 3'd3);
         check("t5_flash_b", lamps(), flash ? 6'b100100 : 6'b000000);
      end
      drive(R, R, 1'b1);
      check("t5_still_fault", fault, 1'b1);
      drive(R, R, 1'b1);
      check("t5_rec_fault", fault, 1'b0);
      check("t5_rec_lamps1", lamps(), 6'b100100);
      check("t5_rec_code", fault_code, 3'd3);
      drive(G, R, 1'b0);
      check("t5_rec_lamps2", lamps(), 6'b100100);
      check("t5_rec_fault2", fault, 1'b0);
      drive(G, R, 1'b0);
      check("t5_resume", lamps(), {G, R});
      check("t5_resume_fault", fault, 1'b0);
      check("t5_resume_code", fault_code, 3'd3);

      // NS red+green together.
      do_reset();
      drive(3'b101, R, 1'b0);
      check("t3_hidden", lamps(), 6'b100100);
      drive(R, R, 1'b0);
      check("t3_fault1", fault, 1'b1);
      check("t3_code1", fault_code, 3'd1);

      // NS green straight to red.
      do_reset();
      drive(G, R, 1'b0);
      drive(R, R, 1'b0);
      check("t3_nofault_yet", fault, 1'b0);
      drive(R, R, 1'b0);
      check("t3_fault4", fault, 1'b1);
      check("t3_code4", fault_code, 3'd4);

      // Yellow held only two cycles.
      do_reset();
      drive(G, R, 1'b0);
      drive(Y, R, 1'b0);
      drive(Y, R, 1'b0);
      drive(R, R, 1'b0);
      check("t4_nofault_yet", fault, 1'b0);
      drive(R, R, 1'b0);
      check("t4_fault5", fault, 1'b1);
      check("t4_code5", fault_code, 3'd5);

      // Reset in the dark half of a flash.
      drive(R, R, 1'b0);
      check("t6_dark", lamps(), 6'b000000);
      reset = 1'b0;
      drive(G, R, 1'b0);
      check("t6_rst_lamps", lamps(), 6'b100100);
      check("t6_rst_fault", fault, 1'b0);
      check("t6_rst_code", fault_code, 3'd0);
      reset = 1'b1;
      drive(G, R, 1'b0);
      check("t6_rel_lamps1", lamps(), 6'b100100);
      drive(G, R, 1'b0);
      check("t6_rel_lamps2", lamps(), {G, R});
      check("t6_rel_fault", fault, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
